// File: rtl/scale_cache_fill_sched_if.sv
// Stream-in / cache-write bundle for the scale cache fill scheduler.
// The slave side is the scheduler; the master side is upstream data plus the cache write port.
interface scale_cache_fill_sched_if #(
   parameter int WORD_SIZE = 32,
   parameter int XW        = 4,
   parameter int YW        = 4
);
   logic [WORD_SIZE-1:0] data;
   logic                 data_ready;
   logic                 data_wanted;
   logic                 we;
   logic [WORD_SIZE-1:0] wdata;
   logic [XW-1:0]        waddrX;
   logic [YW-1:0]        waddrY;
   logic                 wbank;

   modport master (
      output data, data_ready,
      input  data_wanted, we, wdata, waddrX, waddrY, wbank
   );

   modport slave (
      input  data, data_ready,
      output data_wanted, we, wdata, waddrX, waddrY, wbank
   );
endinterface

// File: rtl/scale_cache_fill_sched.sv
// Ping-pong fill scheduler: streams words into one of two cache banks with 2D addressing
// and hands completed banks to the scaler, which reads one bank while the other refills.
//
// state | meaning
// IDLE  | waiting for start; a bank must be free to begin
// FILL  | accepting words, advancing x/y per accepted word
// DONE  | one cycle after the last word; bank is marked complete on exit
module scale_cache_fill_sched #(
   parameter int WORD_SIZE = 32,
   parameter int COLS      = 16,
   parameter int ROWS      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     rd_release,
   output logic                     loaded,
   output logic                     rd_bank,
   output logic                     rd_valid,
   output logic                     start_err,
   output logic                     busy,
   scale_cache_fill_sched_if.slave  bus
);
   localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [1:0]    valid;
   logic          fill_bank;
   logic          accept;
   logic          last_word;
   logic          rel_ok;

   assign bus.data_wanted = (state == FILL);
   assign accept          = bus.data_wanted && bus.data_ready;
   assign last_word       = (x == XW'(COLS - 1)) && (y == YW'(ROWS - 1));
   assign busy            = (state != IDLE);
   assign rd_valid        = valid[rd_bank];
   assign rel_ok          = rd_release && rd_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         x          <= '0;
         y          <= '0;
         valid      <= 2'b00;
         fill_bank  <= 1'b0;
         rd_bank    <= 1'b0;
         loaded     <= 1'b0;
         start_err  <= 1'b0;
         bus.we     <= 1'b0;
         bus.wdata  <= '0;
         bus.waddrX <= '0;
         bus.waddrY <= '0;
         bus.wbank  <= 1'b0;
      end else begin
         bus.we    <= accept;
         loaded    <= 1'b0;
         start_err <= 1'b0;

         if (accept) begin
            bus.wdata  <= bus.data[WORD_SIZE-1:0];
            bus.waddrX <= x;
            bus.waddrY <= y;
            bus.wbank  <= fill_bank;
         end

         // A release never targets the bank being completed: fill_bank differs from rd_bank while rd_valid.
         if (rel_ok) begin
            valid[rd_bank] <= 1'b0;
            rd_bank        <= ~rd_bank;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (valid == 2'b11) begin
                     start_err <= 1'b1;
                  end else begin
                     fill_bank <= valid[rd_bank] ? ~rd_bank : rd_bank;
                     x         <= '0;
                     y         <= '0;
                     state     <= FILL;
                  end
               end
            end
            FILL: begin
               if (start) start_err <= 1'b1;
               if (accept) begin
                  if (x == XW'(COLS - 1)) begin
                     x <= '0;
                     y <= y + 1'b1;
                  end else begin
                     x <= x + 1'b1;
                  end
                  if (last_word) begin
                     loaded <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               if (start) start_err <= 1'b1;
               valid[fill_bank] <= 1'b1;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_scale_cache_fill_sched.sv
// Bench for scale_cache_fill_sched (COLS=4, ROWS=2): vector table, directed corner sequences,
// and random traffic checked every cycle against a word-count based reference model.
module tb_scale_cache_fill_sched;
   localparam int COLS  = 4;
   localparam int ROWS  = 2;
   localparam int TOTAL = COLS * ROWS;
   localparam int WS    = 32;

   logic clk = 1'b0;
   logic reset = 1'b0, start = 1'b0, rd_release = 1'b0;
   logic loaded, rd_bank, rd_valid, start_err, busy;

   scale_cache_fill_sched_if #(.WORD_SIZE(WS), .XW(2), .YW(1)) bus();

   scale_cache_fill_sched #(.WORD_SIZE(WS), .COLS(COLS), .ROWS(ROWS)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rd_release (rd_release),
      .loaded     (loaded),
      .rd_bank    (rd_bank),
      .rd_valid   (rd_valid),
      .start_err  (start_err),
      .busy       (busy),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int wcnt = 0;

   // reference model: phase 0 idle, 1 filling, 2 done; m_n counts accepted words of the fill
   int          m_phase = 0, m_n = 0, m_fill = 0, m_rd = 0;
   bit [1:0]    m_valid = 2'b00;
   bit          e_we = 0, e_loaded = 0, e_err = 0, e_wbank = 0;
   logic [31:0] e_wdata = 0;
   int          e_x = 0, e_y = 0;

   typedef struct {
      bit s, r, rl, rs;
      logic [31:0] d;
      bit wanted, bsy, we, ld, err, rv, rb, wb;
      int x, y;
      logic [31:0] wd;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(bit s, bit r, bit rl, bit rs, logic [31:0] d,
                               bit wanted, bit bsy, bit we, bit ld, bit err, bit rv, bit rb,
                               bit wb, int x, int y, logic [31:0] wd);
      vec_t v;
      v.s = s; v.r = r; v.rl = rl; v.rs = rs; v.d = d;
      v.wanted = wanted; v.bsy = bsy; v.we = we; v.ld = ld; v.err = err;
      v.rv = rv; v.rb = rb; v.wb = wb; v.x = x; v.y = y; v.wd = wd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit s, input bit r, input bit rl, input bit rs,
                             input logic [31:0] d);
      bit       acc;
      bit [1:0] nv;
      int       nrd;
      if (rs) begin
         m_phase = 0; m_n = 0; m_fill = 0; m_rd = 0; m_valid = 2'b00;
         e_we = 0; e_loaded = 0; e_err = 0; e_wbank = 0; e_wdata = 0; e_x = 0; e_y = 0;
         return;
      end
      acc      = (m_phase == 1) && r;
      e_we     = acc;
      e_loaded = acc && (m_n == TOTAL - 1);
      e_err    = s && ((m_phase != 0) || (m_valid == 2'b11));
      if (acc) begin
         e_wdata = d;
         e_x     = m_n % COLS;
         e_y     = m_n / COLS;
         e_wbank = m_fill[0];
      end
      nv  = m_valid;
      nrd = m_rd;
      if (m_phase == 2) nv[m_fill] = 1'b1;
      if (rl && m_valid[m_rd]) begin
         nv[m_rd] = 1'b0;
         nrd      = 1 - m_rd;
      end
      case (m_phase)
         0: if (s && m_valid != 2'b11) begin
               m_fill  = m_valid[m_rd] ? 1 - m_rd : m_rd;
               m_n     = 0;
               m_phase = 1;
            end
         1: if (acc) begin
               m_n++;
               if (m_n == TOTAL) m_phase = 2;
            end
         default: m_phase = 0;
      endcase
      m_valid = nv;
      m_rd    = nrd;
   endtask

   task automatic check_model();
      chk("data_wanted", bus.data_wanted, m_phase == 1);
      chk("busy", busy, m_phase != 0);
      chk("rd_valid", rd_valid, m_valid[m_rd]);
      chk("rd_bank", rd_bank, m_rd);
      chk("we", bus.we, e_we);
      chk("wdata", bus.wdata, e_wdata);
      chk("waddrX", bus.waddrX, e_x);
      chk("waddrY", bus.waddrY, e_y);
      chk("wbank", bus.wbank, e_wbank);
      chk("loaded", loaded, e_loaded);
      chk("start_err", start_err, e_err);
   endtask

   // inputs change at negedge, DUT samples at posedge, outputs checked at the following negedge
   task automatic cycle(input bit s, input bit r, input bit rl, input bit rs, input logic [31:0] d);
      start = s; bus.data_ready = r; rd_release = rl; reset = rs; bus.data = d;
      @(posedge clk);
      model_step(s, r, rl, rs, d);
      @(negedge clk);
      check_model();
      if (rs) wcnt = 0;
      else begin
         if (bus.we) wcnt++;
         if (loaded) begin
            chk("fill_writes", wcnt, TOTAL);
            wcnt = 0;
         end
      end
   endtask

   initial begin
      logic [31:0] dw;
      bus.data = '0;
      bus.data_ready = 1'b0;

      // back-to-back fill into bank 0, then the next start lands in bank 1
      vt.push_back(mk(0,0,0,1, 0,  0,0,0,0,0,0,0,0, 0,0, 0));
      vt.push_back(mk(1,0,0,0, 0,  1,1,0,0,0,0,0,0, 0,0, 0));
      for (int k = 0; k < TOTAL; k++) begin
         dw = 32'hC0DE_0000 + 32'(k);
         vt.push_back(mk(0,1,0,0, dw, (k != TOTAL-1), 1, 1, (k == TOTAL-1), 0, 0, 0, 0,
                         k % COLS, k / COLS, dw));
      end
      vt.push_back(mk(0,0,0,0, 0,  0,0,0,0,0,1,0,0, 3,1, 32'hC0DE_0007));
      vt.push_back(mk(1,1,0,0, 32'h1111,  1,1,0,0,0,1,0,0, 3,1, 32'hC0DE_0007));
      vt.push_back(mk(0,1,0,0, 32'hB1B1_0000,  1,1,1,0,0,1,0,1, 0,0, 32'hB1B1_0000));

      @(negedge clk);
      foreach (vt[i]) begin
         cycle(vt[i].s, vt[i].r, vt[i].rl, vt[i].rs, vt[i].d);
         chk($sformatf("vec%0d_wanted", i), bus.data_wanted, vt[i].wanted);
         chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
         chk($sformatf("vec%0d_we", i), bus.we, vt[i].we);
         chk($sformatf("vec%0d_loaded", i), loaded, vt[i].ld);
         chk($sformatf("vec%0d_err", i), start_err, vt[i].err);
         chk($sformatf("vec%0d_rd_valid", i), rd_valid, vt[i].rv);
         chk($sformatf("vec%0d_rd_bank", i), rd_bank, vt[i].rb);
         chk($sformatf("vec%0d_wbank", i), bus.wbank, vt[i].wb);
         chk($sformatf("vec%0d_x", i), bus.waddrX, vt[i].x);
         chk($sformatf("vec%0d_y", i), bus.waddrY, vt[i].y);
         chk($sformatf("vec%0d_wdata", i), bus.wdata, vt[i].wd);
      end

      // both banks full: start is rejected until the scaler releases one
      for (int k = 1; k < TOTAL; k++) cycle(0, 1, 0, 0, 32'hB1B1_0000 + 32'(k));
      chk("b1_loaded", loaded, 1);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("full_start_err", start_err, 1);
      chk("full_busy", busy, 0);
      chk("full_wanted", bus.data_wanted, 0);
      cycle(0, 0, 1, 0, 0);
      chk("rel_rd_bank", rd_bank, 1);
      chk("rel_rd_valid", rd_valid, 1);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 32'hB0B0_0000);
      chk("refill_wbank", bus.wbank, 0);

      // release coincides with the DONE cycle of the other bank
      for (int k = 1; k < TOTAL; k++) cycle(0, 1, 0, 0, 32'hB0B0_0000 + 32'(k));
      chk("b0_loaded", loaded, 1);
      cycle(0, 0, 1, 0, 0);
      chk("done_rel_valid", dut.valid, 2'b01);
      chk("done_rel_rd_bank", rd_bank, 0);
      chk("done_rel_rd_valid", rd_valid, 1);

      // reset part-way through a fill discards it
      cycle(1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) cycle(0, 1, 0, 0, 32'hDEAD_0000 + 32'(k));
      cycle(0, 0, 0, 1, 0);
      chk("rst_valid", dut.valid, 2'b00);
      chk("rst_we", bus.we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_waddrX", bus.waddrX, 0);
      chk("rst_wdata", bus.wdata, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 32'h5A5A_0000);
      chk("post_rst_wbank", bus.wbank, 0);
      chk("post_rst_x", bus.waddrX, 0);
      chk("post_rst_y", bus.waddrY, 0);

      // stray release and start during a fill
      cycle(0, 1, 1, 0, 32'h5A5A_0001);
      chk("stray_rel_rd_bank", rd_bank, 0);
      chk("stray_rel_rd_valid", rd_valid, 0);
      cycle(1, 1, 0, 0, 32'h5A5A_0002);
      chk("fill_start_err", start_err, 1);
      chk("fill_start_we", bus.we, 1);
      for (int k = 3; k < TOTAL; k++) cycle(0, 1, 0, 0, 32'h5A5A_0000 + 32'(k));
      chk("t6_loaded", loaded, 1);
      cycle(0, 0, 0, 0, 0);
      chk("t6_rd_valid", rd_valid, 1);

      // random traffic with stalls, releases, stray starts and occasional reset
      for (int n = 0; n < 4000; n++) begin
         cycle(($urandom % 6) == 0, ($urandom % 3) != 0, ($urandom % 12) == 0,
               ($urandom % 700) == 0, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
